// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide sequencer: op encodings, FSM states
// and default latencies.
package mdu_pkg;

   typedef enum logic [2:0] {
      MDU_MULT  = 3'd0,
      MDU_MULTU = 3'd1,
      MDU_DIV   = 3'd2,
      MDU_DIVU  = 3'd3,
      MDU_MTHI  = 3'd4,
      MDU_MTLO  = 3'd5,
      MDU_RSV6  = 3'd6,
      MDU_RSV7  = 3'd7
   } mdu_op_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_t;

   localparam int MDU_MULT_CYCLES_DEF = 5;
   localparam int MDU_DIV_CYCLES_DEF  = 10;

   function automatic logic is_div_op(input mdu_op_t op);
      return (op == MDU_DIV) || (op == MDU_DIVU);
   endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational MDU datapath: 64-bit products and signed/unsigned division
// with truncate-toward-zero semantics and a divide-by-zero flag.
module mdu_arith
   import mdu_pkg::*;
(
   input  mdu_op_t     i_op,
   input  logic [31:0] i_a,
   input  logic [31:0] i_b,
   output logic [31:0] o_hi,
   output logic [31:0] o_lo,
   output logic        o_div_by_zero
);

   logic [63:0] w_sprod;
   logic [63:0] w_uprod;
   logic        w_signed;
   logic        w_neg_a;
   logic        w_neg_b;
   logic [31:0] w_dvd;
   logic [31:0] w_dvs;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

   assign w_sprod = $signed({{32{i_a[31]}}, i_a}) * $signed({{32{i_b[31]}}, i_b});
   assign w_uprod = {32'd0, i_a} * {32'd0, i_b};

   // Signed division runs on magnitudes; 0x80000000 / -1 then falls out naturally.
   assign w_signed = (i_op == MDU_DIV);
   assign w_neg_a  = w_signed & i_a[31];
   assign w_neg_b  = w_signed & i_b[31];
   assign w_dvd    = w_neg_a ? (32'd0 - i_a) : i_a;
   assign w_dvs    = (i_b == 32'd0) ? 32'd1 : (w_neg_b ? (32'd0 - i_b) : i_b);
   assign w_quo    = w_dvd / w_dvs;
   assign w_rem    = w_dvd % w_dvs;

   assign o_div_by_zero = is_div_op(i_op) && (i_b == 32'd0);

   // Select the result pair for the requested operation.
   always_comb begin
      o_hi = 32'd0;
      o_lo = 32'd0;
      case (i_op)
         MDU_MULT:  {o_hi, o_lo} = w_sprod;
         MDU_MULTU: {o_hi, o_lo} = w_uprod;
         MDU_DIV, MDU_DIVU: begin
            o_lo = (w_neg_a ^ w_neg_b) ? (32'd0 - w_quo) : w_quo;
            o_hi = w_neg_a ? (32'd0 - w_rem) : w_rem;
         end
         default: begin
            o_hi = 32'd0;
            o_lo = 32'd0;
         end
      endcase
   end

endmodule

// File: rtl/mdu_sequencer.sv
// Multiply/divide sequencer: owns HI/LO, holds busy for a fixed latency per op
// and commits the result from operands latched at start.
module mdu_sequencer
   import mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MDU_MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = MDU_DIV_CYCLES_DEF
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic        busy,
   output logic [31:0] HI,
   output logic [31:0] LO
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

   mdu_state_t       r_state;
   mdu_state_t       w_state_nxt;
   mdu_op_t          w_op;
   mdu_op_t          r_op;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_latency;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic [31:0]      r_hi;
   logic [31:0]      r_lo;
   logic             r_busy;
   logic             w_accept;
   logic             w_mthi;
   logic             w_mtlo;
   logic             w_commit;
   logic [31:0]      w_res_hi;
   logic [31:0]      w_res_lo;
   logic             w_div_by_zero;

   assign w_op      = mdu_op_t'(op);
   assign w_latency = is_div_op(w_op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);

   mdu_arith u_arith (
      .i_op          (r_op),
      .i_a           (r_a),
      .i_b           (r_b),
      .o_hi          (w_res_hi),
      .o_lo          (w_res_lo),
      .o_div_by_zero (w_div_by_zero)
   );

   // FSM state register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_nxt;
   end

   // Next-state and control decode; starts arriving during RUN are dropped.
   always_comb begin
      w_state_nxt = r_state;
      w_accept    = 1'b0;
      w_mthi      = 1'b0;
      w_mtlo      = 1'b0;
      w_commit    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               case (w_op)
                  MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                     w_accept    = 1'b1;
                     w_state_nxt = ST_RUN;
                  end
                  MDU_MTHI: w_mthi = 1'b1;
                  MDU_MTLO: w_mtlo = 1'b1;
                  default:  w_state_nxt = ST_IDLE;
               endcase
            end else begin
               w_state_nxt = ST_IDLE;
            end
         end
         ST_RUN: begin
            if (r_cnt == CNT_W'(1)) begin
               w_commit    = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_state_nxt = ST_RUN;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Busy flag and latency counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_busy <= 1'b0;
         r_cnt  <= {CNT_W{1'b0}};
      end else if (w_accept) begin
         r_busy <= 1'b1;
         r_cnt  <= w_latency;
      end else if (w_commit) begin
         r_busy <= 1'b0;
         r_cnt  <= {CNT_W{1'b0}};
      end else if (r_state == ST_RUN) begin
         r_cnt  <= r_cnt - CNT_W'(1);
      end
   end

   // Operand latches, so later changes on A/B cannot disturb the result.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_op <= MDU_MULT;
         r_a  <= 32'd0;
         r_b  <= 32'd0;
      end else if (w_accept) begin
         r_op <= w_op;
         r_a  <= A;
         r_b  <= B;
      end
   end

   // HI/LO: commit (skipped on divide by zero) or direct moves from A.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_hi <= 32'd0;
         r_lo <= 32'd0;
      end else if (w_commit) begin
         if (!w_div_by_zero) begin
            r_hi <= w_res_hi;
            r_lo <= w_res_lo;
         end
      end else if (w_mthi) begin
         r_hi <= A;
      end else if (w_mtlo) begin
         r_lo <= A;
      end
   end

   assign busy = r_busy;
   assign HI   = r_hi;
   assign LO   = r_lo;

endmodule
